// File: rtl/rv32i_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle controller.
package rv32i_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    TRAP    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    R       = 3'd1,
    LOAD    = 3'd2,
    STORE   = 3'd3,
    IALU    = 3'd4,
    ILLEGAL = 3'd5
  } class_e;

  localparam logic [6:0] OP_R_TYPE  = 7'b0110011;
  localparam logic [6:0] OP_IL_TYPE = 7'b0000011;
  localparam logic [6:0] OP_S_TYPE  = 7'b0100011;
  localparam logic [6:0] OP_I_TYPE  = 7'b0010011;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  // Immediate ALU ops only use bit 30 to tell SRAI from SRLI.
  function automatic logic [3:0] iAluCode(input logic bit30, input logic [2:0] funct3);
    return {(funct3 == 3'b101) ? bit30 : 1'b0, funct3};
  endfunction

endpackage

// File: rtl/rv32i_inst_class.sv
// Opcode to instruction-class map. RV32I_IALU_EN enables the OP-IMM class.
module rv32i_inst_class
  import rv32i_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] instClass
);

  always_comb begin
    instClass = ILLEGAL;
    case (opcode)
      OP_R_TYPE:  instClass = R;
      OP_IL_TYPE: instClass = LOAD;
      OP_S_TYPE:  instClass = STORE;
`ifdef RV32I_IALU_EN
      OP_I_TYPE:  instClass = IALU;
`else
      OP_I_TYPE:  instClass = ILLEGAL;
`endif
      default:    instClass = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with illegal-op and bus-timeout trap.
// Optional OP-IMM support via RV32I_IALU_EN (see rv32i_inst_class).
module rv32i_multicycle_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [31:0] iInst_Code,
  input  logic        iInst_Valid,
  input  logic        iMem_Ack,
  output logic        oInst_Req,
  output logic        oIR_WrEn,
  output logic        oPC_WrEn,
  output logic [2:0]  oFunct3,
  output logic [3:0]  oALU_Control,
  output logic        oALUSrcMuxSel,
  output logic        oRegWrDataSel,
  output logic        oReg_WrEn,
  output logic        oData_RdEn,
  output logic        oData_WrEn,
  output logic        oTrap,
  output logic [2:0]  oState
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_e         state;
  class_e         instClass;
  logic [CW-1:0]  memCnt;
  logic           trapReg;
  logic [2:0]     decClassRaw;
  class_e         decClass;
  logic [2:0]     funct3;
  logic           unusedInst;

  assign funct3     = iInst_Code[14:12];
  assign unusedInst = ^{iInst_Code[31], iInst_Code[29:15], iInst_Code[11:7]};

  rv32i_inst_class uClass (
    .opcode    (iInst_Code[6:0]),
    .instClass (decClassRaw)
  );

  assign decClass = class_e'(decClassRaw);

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state     <= FETCH;
      instClass <= NONE;
      memCnt    <= '0;
      trapReg   <= 1'b0;
    end else begin
      case (state)
        FETCH: if (iInst_Valid) state <= DECODE;
        DECODE: begin
          instClass <= decClass;
          if (decClass == ILLEGAL) begin
            state   <= TRAP;
            trapReg <= 1'b1;
          end else begin
            state <= EXECUTE;
          end
        end
        EXECUTE: begin
          case (instClass)
            R, IALU: state <= WB;
            LOAD, STORE: begin
              state  <= MEM;
              memCnt <= '0;
            end
            default: begin
              state   <= TRAP;
              trapReg <= 1'b1;
            end
          endcase
        end
        MEM: begin
          // An ack on the expiry cycle still completes the access.
          if (iMem_Ack) begin
            state <= (instClass == STORE) ? FETCH : WB;
          end else begin
            memCnt <= memCnt + 1'b1;
            if (memCnt == CW'(TIMEOUT_CYC - 1)) begin
              state   <= TRAP;
              trapReg <= 1'b1;
            end
          end
        end
        WB:      state <= FETCH;
        TRAP:    state <= TRAP;
        default: state <= TRAP;
      endcase
    end
  end

  logic       instReq, irWrEn, pcWrEn, aluSrc, wrDataSel, regWrEn, rdEn, wrEn;
  logic [3:0] aluCtl;

  always_comb begin
    instReq   = 1'b0;
    irWrEn    = 1'b0;
    pcWrEn    = 1'b0;
    aluSrc    = 1'b0;
    wrDataSel = 1'b0;
    regWrEn   = 1'b0;
    rdEn      = 1'b0;
    wrEn      = 1'b0;
    aluCtl    = ALU_ADD;
    case (state)
      FETCH: begin
        instReq = 1'b1;
        irWrEn  = iInst_Valid;
      end
      EXECUTE: begin
        case (instClass)
          R: aluCtl = {iInst_Code[30], funct3};
          IALU: begin
            aluCtl = iAluCode(iInst_Code[30], funct3);
            aluSrc = 1'b1;
          end
          LOAD, STORE: aluSrc = 1'b1;
          default: ;
        endcase
      end
      MEM: begin
        aluSrc = 1'b1;
        if (instClass == LOAD) rdEn = 1'b1;
        if (instClass == STORE) begin
          wrEn   = 1'b1;
          pcWrEn = iMem_Ack;
        end
      end
      WB: begin
        regWrEn   = 1'b1;
        pcWrEn    = 1'b1;
        wrDataSel = (instClass == LOAD);
      end
      default: ;
    endcase
  end

  // Reset gates every control output so an aborted instruction writes nothing.
  assign oInst_Req     = iRst_n & instReq;
  assign oIR_WrEn      = iRst_n & irWrEn;
  assign oPC_WrEn      = iRst_n & pcWrEn;
  assign oALUSrcMuxSel = iRst_n & aluSrc;
  assign oRegWrDataSel = iRst_n & wrDataSel;
  assign oReg_WrEn     = iRst_n & regWrEn;
  assign oData_RdEn    = iRst_n & rdEn;
  assign oData_WrEn    = iRst_n & wrEn;
  assign oTrap         = iRst_n & trapReg;
  assign oALU_Control  = iRst_n ? aluCtl : 4'b0000;
  assign oState        = iRst_n ? state : 3'd0;
  assign oFunct3       = funct3;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Cycle-by-cycle check of the RV32I multi-cycle controller against hand-written expected vectors.
module tb_rv32i_multicycle_ctrl;

  logic        iClk = 1'b0;
  logic        iRst_n, iInst_Valid, iMem_Ack;
  logic [31:0] iInst_Code;
  logic        oInst_Req, oIR_WrEn, oPC_WrEn, oALUSrcMuxSel, oRegWrDataSel;
  logic        oReg_WrEn, oData_RdEn, oData_WrEn, oTrap;
  logic [2:0]  oFunct3, oState;
  logic [3:0]  oALU_Control;

  always #5 iClk = ~iClk;

  rv32i_multicycle_ctrl #(.TIMEOUT_CYC(16)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iInst_Code(iInst_Code), .iInst_Valid(iInst_Valid),
    .iMem_Ack(iMem_Ack), .oInst_Req(oInst_Req), .oIR_WrEn(oIR_WrEn), .oPC_WrEn(oPC_WrEn),
    .oFunct3(oFunct3), .oALU_Control(oALU_Control), .oALUSrcMuxSel(oALUSrcMuxSel),
    .oRegWrDataSel(oRegWrDataSel), .oReg_WrEn(oReg_WrEn), .oData_RdEn(oData_RdEn),
    .oData_WrEn(oData_WrEn), .oTrap(oTrap), .oState(oState)
  );

  // Flag word: {InstReq, IRWr, PCWr, ALUSrc, WrDataSel, RegWr, RdEn, WrEn, Trap}
  localparam logic [8:0] IRQ = 9'h100, IRW = 9'h080, PCW = 9'h040, SRC = 9'h020, WDS = 9'h010;
  localparam logic [8:0] RGW = 9'h008, RDE = 9'h004, WRE = 9'h002, TRP = 9'h001, NOF = 9'h000;
  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW_ = 3'd4, ST = 3'd5;
  localparam logic [31:0] I_ADD = 32'h002081B3, I_SUB = 32'h402081B3, I_LW = 32'h0000A183;
  localparam logic [31:0] I_SW  = 32'h0030A023, I_ILL = 32'h0000007F;

  typedef struct {
    logic        rst;
    logic [31:0] inst;
    logic        valid;
    logic        ack;
    logic [2:0]  st;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic [8:0]  fl;
    string       tag;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic rst, input logic [31:0] inst, input logic valid,
                              input logic ack, input logic [2:0] st, input logic [3:0] alu,
                              input logic [8:0] fl, input string tag);
    vec_t v;
    v.rst = rst; v.inst = inst; v.valid = valid; v.ack = ack;
    v.st = st; v.alu = alu; v.fl = fl; v.tag = tag;
    v.f3 = inst[14:12];
    return v;
  endfunction

  task automatic step(input vec_t v);
    vec_t e;
    logic [8:0] fl;
    iRst_n = v.rst; iInst_Code = v.inst; iInst_Valid = v.valid; iMem_Ack = v.ack;
    sb.push_back(v);
    @(negedge iClk);
    e  = sb.pop_front();
    fl = {oInst_Req, oIR_WrEn, oPC_WrEn, oALUSrcMuxSel, oRegWrDataSel,
          oReg_WrEn, oData_RdEn, oData_WrEn, oTrap};
    checks++;
    if (oState !== e.st || oALU_Control !== e.alu || oFunct3 !== e.f3 || fl !== e.fl) begin
      errors++;
      $display("FAIL %s @%0t: got st=%0d alu=%b f3=%0d fl=%b, want st=%0d alu=%b f3=%0d fl=%b",
               e.tag, $time, oState, oALU_Control, oFunct3, fl, e.st, e.alu, e.f3, e.fl);
    end
    @(posedge iClk);
    #1;
  endtask

  initial begin
    iRst_n = 1'b0; iInst_Code = '0; iInst_Valid = 1'b0; iMem_Ack = 1'b0;
    @(posedge iClk);
    #1;

    tbl.push_back(mk(0, 32'h0, 0, 0, SF, 4'h0, NOF, "reset0"));
    tbl.push_back(mk(0, 32'h0, 1, 1, SF, 4'h0, NOF, "reset1"));
    tbl.push_back(mk(1, I_ADD, 1, 1, SF, 4'h0, IRQ | IRW, "add_F"));
    tbl.push_back(mk(1, I_ADD, 1, 1, SD, 4'h0, NOF, "add_D"));
    tbl.push_back(mk(1, I_ADD, 1, 1, SE, 4'h0, NOF, "add_E"));
    tbl.push_back(mk(1, I_ADD, 1, 1, SW_, 4'h0, RGW | PCW, "add_W"));
    tbl.push_back(mk(1, I_SUB, 1, 1, SF, 4'h0, IRQ | IRW, "sub_F"));
    tbl.push_back(mk(1, I_SUB, 1, 1, SD, 4'h0, NOF, "sub_D"));
    tbl.push_back(mk(1, I_SUB, 1, 1, SE, 4'b1000, NOF, "sub_E"));
    tbl.push_back(mk(1, I_SUB, 1, 1, SW_, 4'h0, RGW | PCW, "sub_W"));
    tbl.push_back(mk(1, I_LW, 1, 0, SF, 4'h0, IRQ | IRW, "lw_F"));
    tbl.push_back(mk(1, I_LW, 1, 1, SD, 4'h0, NOF, "lw_D"));
    tbl.push_back(mk(1, I_LW, 1, 1, SE, 4'h0, SRC, "lw_E"));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, I_LW, 1, 0, SM, 4'h0, SRC | RDE, "lw_Mwait"));
    tbl.push_back(mk(1, I_LW, 1, 1, SM, 4'h0, SRC | RDE, "lw_Mack"));
    tbl.push_back(mk(1, I_LW, 1, 0, SW_, 4'h0, RGW | PCW | WDS, "lw_W"));
    tbl.push_back(mk(1, I_SW, 1, 0, SF, 4'h0, IRQ | IRW, "sw_F"));
    tbl.push_back(mk(1, I_SW, 1, 1, SD, 4'h0, NOF, "sw_D"));
    tbl.push_back(mk(1, I_SW, 1, 1, SE, 4'h0, SRC, "sw_E"));
    tbl.push_back(mk(1, I_SW, 1, 1, SM, 4'h0, SRC | WRE | PCW, "sw_Mack"));
    tbl.push_back(mk(1, I_SW, 0, 1, SF, 4'h0, IRQ, "fetch_wait0"));
    tbl.push_back(mk(1, I_SW, 0, 1, SF, 4'h0, IRQ, "fetch_wait1"));
    tbl.push_back(mk(1, I_ILL, 1, 0, SF, 4'h0, IRQ | IRW, "ill_F"));
    tbl.push_back(mk(1, I_ILL, 1, 0, SD, 4'h0, NOF, "ill_D"));
    tbl.push_back(mk(1, I_ILL, 1, 0, ST, 4'h0, TRP, "ill_T"));

    foreach (tbl[i]) step(tbl[i]);

    // Trap is sticky regardless of valid/ack activity, and cleared by one reset edge.
    for (int i = 0; i < 20; i++) step(mk(1, I_ADD, 1, 1, ST, 4'h0, TRP, "trap_hold"));
    step(mk(0, I_ADD, 1, 1, SF, 4'h0, NOF, "trap_rst"));
    step(mk(1, I_ADD, 0, 0, SF, 4'h0, IRQ, "trap_exit"));

    // Load with no ack: 16 MEM cycles then TRAP.
    step(mk(1, I_LW, 1, 0, SF, 4'h0, IRQ | IRW, "to_F"));
    step(mk(1, I_LW, 1, 0, SD, 4'h0, NOF, "to_D"));
    step(mk(1, I_LW, 1, 0, SE, 4'h0, SRC, "to_E"));
    for (int i = 0; i < 16; i++) step(mk(1, I_LW, 1, 0, SM, 4'h0, SRC | RDE, "to_M"));
    step(mk(1, I_LW, 1, 0, ST, 4'h0, TRP, "to_T"));
    step(mk(0, I_LW, 0, 0, SF, 4'h0, NOF, "to_rst"));

    // Ack on the 16th MEM cycle wins over the timeout.
    step(mk(1, I_LW, 1, 0, SF, 4'h0, IRQ | IRW, "late_F"));
    step(mk(1, I_LW, 1, 0, SD, 4'h0, NOF, "late_D"));
    step(mk(1, I_LW, 1, 0, SE, 4'h0, SRC, "late_E"));
    for (int i = 0; i < 15; i++) step(mk(1, I_LW, 1, 0, SM, 4'h0, SRC | RDE, "late_M"));
    step(mk(1, I_LW, 1, 1, SM, 4'h0, SRC | RDE, "late_Mack"));
    step(mk(1, I_LW, 1, 0, SW_, 4'h0, RGW | PCW | WDS, "late_W"));
    step(mk(1, I_LW, 0, 0, SF, 4'h0, IRQ, "late_F2"));

    // Reset during a store: no write strobes, restart in FETCH.
    step(mk(1, I_SW, 1, 0, SF, 4'h0, IRQ | IRW, "abort_F"));
    step(mk(1, I_SW, 1, 0, SD, 4'h0, NOF, "abort_D"));
    step(mk(1, I_SW, 1, 0, SE, 4'h0, SRC, "abort_E"));
    step(mk(0, I_SW, 1, 1, SF, 4'h0, NOF, "abort_rst"));
    step(mk(1, I_SW, 0, 1, SF, 4'h0, IRQ, "abort_F2"));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
